// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Shared ALU operation codes, opcode-match constants, sequencer
//            state encoding and the combinational decode function used by
//            alu_ctrl_seq.
// Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  // inst[31:21] patterns for the ops that need the full opcode field
  localparam logic [10:0] OPC_MUL = 11'b10011011000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
    logic       is_mul;
  } dec_t;

  // Priority decode: the first matching row wins. Because alu_op[0]=1 is
  // caught early, every later "1x" row can only see alu_op=10.
  function automatic dec_t decode(input logic [1:0] alu_op, input logic [31:0] inst);
    logic [2:0] f;
    dec_t       d;
    f = {inst[30], inst[29], inst[24]};
    d = '{code: ALU_AND, illegal: 1'b0, is_mul: 1'b0};
    if (alu_op == 2'b00)                                d.code = ALU_ADD;
    else if (alu_op[0])                                 d.code = ALU_PASSB;
    else if (alu_op == 2'b10 && inst[31:21] == OPC_MUL) begin
      d.code   = ALU_MUL;
      d.is_mul = 1'b1;
    end
    else if (alu_op == 2'b10 && inst[31:21] == OPC_LSL) d.code = ALU_LSL;
    else if (alu_op == 2'b10 && inst[31:21] == OPC_LSR) d.code = ALU_LSR;
    else if (alu_op[1] && f == 3'b001)                  d.code = ALU_ADD;
    else if (alu_op[1] && f == 3'b101)                  d.code = ALU_SUB;
    else if (alu_op == 2'b10 && f == 3'b000)            d.code = ALU_AND;
    else if (alu_op[1] && f == 3'b010)                  d.code = ALU_ORR;
    else                                                d.illegal = 1'b1;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_seq_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter
// Purpose  : Iterative shift-add multiplier retiring MUL_STEP multiplier bits
//            per step. Produces the low DATA_W bits of a*b.
// Ports    : clk, rst     clock / async active-high reset
//            start        latch operands, clear accumulator, load counter
//            step         retire MUL_STEP bits this cycle
//            a, b         multiplicand / multiplier
//            done         current step is the last one
//            result       accumulator including the current step's partial
// Revision : 1.0  initial release
// ============================================================================
module mul_iter #(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int c_steps = DATA_W / MUL_STEP;
  localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;

  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_mcand;
  logic [DATA_W-1:0]  r_mplier;
  logic [c_cnt_w-1:0] r_cnt;
  logic [DATA_W-1:0]  w_pp;

  // Partial product of the shifted multiplicand and the low MUL_STEP
  // multiplier bits; bits shifted past DATA_W are discarded on purpose.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  assign result = r_acc + w_pp;
  assign done   = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_cnt    <= c_cnt_w'(c_steps - 1);
    end else if (step) begin
      r_acc    <= result;
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      if (!done) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Purpose  : Handshaked ALU-control decoder with registered outputs, shift
//            and illegal-op decode, and an iterative MUL sequencer.
// Ports    : clk, rst, flush           clock, async reset, sync abort
//            in_valid/in_ready         request handshake
//            alu_op, inst, op_a, op_b  request fields
//            out_valid/out_ready       result handshake
//            alu_code, res_sel, mul_result, shamt, illegal  result fields
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1,
  parameter int INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [INST_W-1:0] inst,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_code,
  output logic              res_sel,
  output logic [DATA_W-1:0] mul_result,
  output logic [5:0]        shamt,
  output logic              illegal
);

  state_t            r_state;
  state_t            w_state_nxt;
  dec_t              w_dec;
  logic              w_accept;
  logic              w_start;
  logic              w_step;
  logic              w_done;
  logic [DATA_W-1:0] w_prod;

  assign w_dec    = decode(alu_op, inst[31:0]);
  assign in_ready = (r_state == IDLE) && (!out_valid || out_ready);
  // An accept coinciding with flush is dropped.
  assign w_accept = in_valid && in_ready && !flush;

  mul_iter #(
    .DATA_W   (DATA_W),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .step   (w_step),
    .a      (op_a),
    .b      (op_b),
    .done   (w_done),
    .result (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_dec.is_mul) begin
          w_state_nxt = BUSY;
          w_start     = 1'b1;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_start     = 1'b0;
      w_step      = 1'b0;
    end
  end

  // Output register. A MUL accept only happens when the output slot is empty
  // or being drained, so the slot is always free when the product lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_code   <= ALU_AND;
      res_sel    <= 1'b0;
      mul_result <= '0;
      shamt      <= '0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (r_state == BUSY && w_done) begin
        // shamt is left at its previous value; it is meaningless for MUL.
        out_valid  <= 1'b1;
        alu_code   <= ALU_MUL;
        res_sel    <= 1'b1;
        mul_result <= w_prod;
        illegal    <= 1'b0;
      end else if (w_accept && !w_dec.is_mul) begin
        out_valid <= 1'b1;
        alu_code  <= w_dec.code;
        res_sel   <= 1'b0;
        shamt     <= inst[15:10];
        illegal   <= w_dec.illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Purpose  : Directed self-checking bench for alu_ctrl_seq (default params)
//            plus a MUL_STEP=4 instance for the short-latency multiply.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid4 = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [31:0] inst = '0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, res_sel, illegal;
  logic [3:0]  alu_code;
  logic [63:0] mul_result;
  logic [5:0]  shamt;
  logic        in_ready4, out_valid4, res_sel4, illegal4;
  logic [3:0]  alu_code4;
  logic [63:0] mul_result4;
  logic [5:0]  shamt4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(64), .MUL_STEP(1), .INST_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .inst(inst), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .alu_code(alu_code),
    .res_sel(res_sel), .mul_result(mul_result), .shamt(shamt), .illegal(illegal)
  );

  alu_ctrl_seq #(.DATA_W(64), .MUL_STEP(4), .INST_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op), .inst(inst), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid4), .out_ready(out_ready), .alu_code(alu_code4),
    .res_sel(res_sel4), .mul_result(mul_result4), .shamt(shamt4), .illegal(illegal4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rt(input logic [2:0] f);
    logic [31:0] w;
    w = '0;
    w[30] = f[2];
    w[29] = f[1];
    w[24] = f[0];
    return w;
  endfunction

  function automatic logic [31:0] opc(input logic [10:0] o, input logic [5:0] sh);
    logic [31:0] w;
    w = {o, 21'b0};
    w[15:10] = sh;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one non-MUL request and checks the latency-1 result fields.
  task automatic do_op(input string tag, input logic [1:0] aop, input logic [31:0] ins,
                       input logic [3:0] exp_code, input logic exp_ill);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    alu_op   = aop;
    inst     = ins;
    step();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_alu_code"}, 64'(alu_code), 64'(exp_code));
    chk({tag, "_res_sel"}, 64'(res_sel), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
  endtask

  task automatic do_mul(input string tag, input bit wide4, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    int ready_hi;
    chk({tag, "_in_ready"}, 64'(wide4 ? in_ready4 : in_ready), 64'd1);
    alu_op = 2'b10;
    inst   = opc(11'b10011011000, 6'd0);
    op_a   = a;
    op_b   = b;
    if (wide4) in_valid4 = 1'b1; else in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    lat      = 1;
    ready_hi = 0;
    while (!(wide4 ? out_valid4 : out_valid) && lat < 200) begin
      if (wide4 ? in_ready4 : in_ready) ready_hi++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ready_while_busy"}, 64'(ready_hi), 64'd0);
    chk({tag, "_mul_result"}, wide4 ? mul_result4 : mul_result, exp);
    chk({tag, "_alu_code"}, 64'(wide4 ? alu_code4 : alu_code), 64'b1000);
    chk({tag, "_res_sel"}, 64'(wide4 ? res_sel4 : res_sel), 64'd1);
  endtask

  initial begin
    int seen;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_code", 64'(alu_code), 64'd0);
    chk("rst_res_sel", 64'(res_sel), 64'd0);
    chk("rst_mul_result", mul_result, 64'd0);
    chk("rst_shamt", 64'(shamt), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Decode sweep, back-to-back with out_ready=1
    do_op("sub",   2'b10, rt(3'b101), 4'b0110, 1'b0);
    do_op("and",   2'b10, rt(3'b000), 4'b0000, 1'b0);
    do_op("orr",   2'b10, rt(3'b010), 4'b0001, 1'b0);
    do_op("add_r", 2'b10, rt(3'b001), 4'b0010, 1'b0);
    do_op("add_m", 2'b00, rt(3'b101), 4'b0010, 1'b0);
    do_op("passb", 2'b01, rt(3'b000), 4'b0111, 1'b0);
    do_op("ill",   2'b10, rt(3'b111), 4'b0000, 1'b1);
    do_op("lsl",   2'b10, opc(11'b11010011011, 6'd13), 4'b0011, 1'b0);
    chk("lsl_shamt", 64'(shamt), 64'd13);
    do_op("lsr",   2'b10, opc(11'b11010011010, 6'd5), 4'b0100, 1'b0);
    chk("lsr_shamt", 64'(shamt), 64'd5);
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Multiplies
    do_mul("mul1",  1'b0, 64'h1234, 64'h10, 64'h12340, 65);
    step();
    do_op("sub_after_mul", 2'b10, rt(3'b101), 4'b0110, 1'b0);
    chk("mul_result_held", mul_result, 64'h12340);
    step();
    do_mul("mulff", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65);
    step();
    do_mul("mul4",  1'b1, 64'h1234, 64'h10, 64'h12340, 17);
    step();

    // Back-pressure hold, then drain with a simultaneous AND accept
    out_ready = 1'b0;
    do_op("bp_sub", 2'b10, rt(3'b101), 4'b0110, 1'b0);
    in_valid = 1'b1;
    alu_op   = 2'b10;
    inst     = rt(3'b000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_code", 64'(alu_code), 64'b0110);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_alu_code", 64'(alu_code), 64'b0000);
    step();

    // Flush coinciding with an accept drops it
    in_valid = 1'b1;
    alu_op   = 2'b00;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_drop_valid", 64'(out_valid), 64'd0);

    // Flush at BUSY cycle 10
    alu_op   = 2'b10;
    inst     = opc(11'b10011011000, 6'd0);
    op_a     = 64'd7;
    op_b     = 64'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("flush_no_output", 64'(seen), 64'd0);
    do_op("add_after_flush", 2'b00, 32'd0, 4'b0010, 1'b0);
    step();

    // Async reset between edges during a MUL
    alu_op   = 2'b10;
    inst     = opc(11'b10011011000, 6'd0);
    op_a     = 64'd3;
    op_b     = 64'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_alu_code", 64'(alu_code), 64'd0);
    chk("arst_mul_result", mul_result, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step();
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("arst_no_output", 64'(seen), 64'd0);
    do_op("add_after_rst", 2'b00, 32'd0, 4'b0010, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
